// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main sequencing FSM of the multi-cycle RV32I core
// Walks each instruction through fetch/decode/execute/mem/writeback and drives all enables.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       pc_write,
  output logic       pc_sel,
  output logic [2:0] alu_op,
  output logic       retired,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_AUIPC, C_JUMP
  } cls_e;

  localparam logic [2:0] ALU_IDLE = 3'd7;
  localparam logic [2:0] ALU_MEM  = 3'd3;

  state_e state_q, state_d;
  cls_e   cls_q;
  cls_e   dec_cls;
  logic   dec_legal;
  logic [2:0] cls_alu;

  always_comb begin
    dec_cls   = C_R;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0110111: dec_cls = C_LUI;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111,
      7'b1100111: dec_cls = C_JUMP;
      default:    dec_legal = 1'b0;
    endcase
  end

  // Loads and stores share the address-add ALU class.
  always_comb begin
    cls_alu = ALU_IDLE;
    case (cls_q)
      C_R:      cls_alu = 3'd0;
      C_I:      cls_alu = 3'd1;
      C_LUI:    cls_alu = 3'd2;
      C_LOAD:   cls_alu = 3'd3;
      C_STORE:  cls_alu = 3'd3;
      C_BRANCH: cls_alu = 3'd4;
      C_AUIPC:  cls_alu = 3'd5;
      C_JUMP:   cls_alu = 3'd6;
      default:  cls_alu = ALU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && dec_legal) begin
        cls_q <= dec_cls;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    alu_op       = ALU_IDLE;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = dec_legal ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        alu_op = cls_alu;
        if (cls_q == C_BRANCH) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          state_d  = S_FETCH;
        end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        alu_op       = ALU_MEM;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        alu_op    = cls_alu;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = (cls_q == C_LOAD);
        pc_sel    = (cls_q == C_JUMP);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // Reset masks every output in the cycle it is asserted, aborting any instruction.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      alu_op       = ALU_IDLE;
      illegal      = 1'b0;
    end
  end

  assign retired = pc_write;

endmodule
